// File: rtl/video_axis_pkg.sv
// Shared video AXI4-Stream definitions for the conformer and barrel_distortion_correction.
// Holds the conformer state encoding and the default frame geometry.
// Also provides a saturating 16-bit increment used by the optional statistics counters.
package video_axis_pkg;

   localparam int DEF_WIDTH       = 1920;
   localparam int DEF_HEIGHT      = 1080;
   localparam int DEF_DATA_WIDTH  = 24;
   localparam int DEF_COORD_WIDTH = 16;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      PASS     = 2'd1,
      PAD      = 2'd2,
      DROP     = 2'd3
   } conf_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register carrying tdata/tlast/tuser.
// Latency: 1 cycle from load to visible output.
// Backpressure: loads only on i_out_en, so contents stay frozen while valid && !ready.
module axis_out_reg #(
   parameter int DATA_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_out_en,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_dat,
   input  logic                  i_last,
   input  logic                  i_user,
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_dat,
   output logic                  o_last,
   output logic                  o_user
);

   logic                  r_vld;
   logic [DATA_WIDTH-1:0] r_dat;
   logic                  r_last;
   logic                  r_user;

   // Capture a new beat (or an empty slot) whenever the slot is free or being drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_dat  <= '0;
         r_last <= 1'b0;
         r_user <= 1'b0;
      end else if (i_out_en) begin
         r_vld  <= i_vld;
         r_dat  <= i_dat;
         r_last <= i_last;
         r_user <= i_user;
      end
   end

   assign o_vld  = r_vld;
   assign o_dat  = r_dat;
   assign o_last = r_last;
   assign o_user = r_user;

endmodule

// File: rtl/axis_frame_conformer.sv
// Forces an arbitrary AXI4-Stream video source into exact WIDTH x HEIGHT frames (pad/truncate/drop).
// Latency: 1 cycle input acceptance to m_axis_tvalid, 1 pixel/clk sustained.
// Backpressure: s_axis_tready follows the output slot; optional stats via AXIS_FRAME_CONFORMER_STATS_EN.
module axis_frame_conformer
   import video_axis_pkg::*;
#(
   parameter int                    WIDTH       = DEF_WIDTH,
   parameter int                    HEIGHT      = DEF_HEIGHT,
   parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int                    COORD_WIDTH = DEF_COORD_WIDTH,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic                  err_short_line,
   output logic                  err_long_line,
   output logic                  err_early_sof,
   output logic                  frame_done
`ifdef AXIS_FRAME_CONFORMER_STATS_EN
   ,
   input  logic                  stats_clr,
   output logic [15:0]           cnt_short_line,
   output logic [15:0]           cnt_long_line,
   output logic [15:0]           cnt_early_sof,
   output logic [15:0]           cnt_frames
`endif
);

   localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
   localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);
   localparam logic [COORD_WIDTH-1:0] C_ONE  = COORD_WIDTH'(1);

   conf_state_t            r_state;
   logic [COORD_WIDTH-1:0] r_x;
   logic [COORD_WIDTH-1:0] r_y;
   logic                   r_drop_eof;   // the line being dropped was the last of the frame
   logic                   r_out_eof;    // output slot holds pixel (WIDTH-1,HEIGHT-1)

   conf_state_t            w_state_nxt;
   logic [COORD_WIDTH-1:0] w_x_nxt;
   logic [COORD_WIDTH-1:0] w_y_nxt;
   logic                   w_drop_eof_nxt;
   logic [COORD_WIDTH-1:0] w_cx;
   logic [COORD_WIDTH-1:0] w_cy;
   logic                   w_emit;
   logic                   w_out_en;
   logic                   w_tready;
   logic                   w_load;
   logic [DATA_WIDTH-1:0]  w_dat;
   logic                   w_last;
   logic                   w_user;
   logic                   w_eof;
   logic                   w_short;
   logic                   w_long;
   logic                   w_sof_err;

   assign w_out_en = !m_axis_tvalid || m_axis_tready;

   // State, coordinates and drop destination.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= WAIT_SOF;
         r_x        <= '0;
         r_y        <= '0;
         r_drop_eof <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_drop_eof <= w_drop_eof_nxt;
      end
   end

   // Next state, input ready, output beat and anomaly pulses.
   always_comb begin
      w_state_nxt    = r_state;
      w_x_nxt        = r_x;
      w_y_nxt        = r_y;
      w_drop_eof_nxt = r_drop_eof;
      w_cx           = r_x;
      w_cy           = r_y;
      w_emit         = 1'b0;
      w_tready       = 1'b0;
      w_load         = 1'b0;
      w_dat          = '0;
      w_last         = 1'b0;
      w_user         = 1'b0;
      w_eof          = 1'b0;
      w_short        = 1'b0;
      w_long         = 1'b0;
      w_sof_err      = 1'b0;

      case (r_state)
         WAIT_SOF: begin
            // Garbage is always swallowed; an SOF beat must wait for a free output slot.
            w_tready = w_out_en || !s_axis_tuser;
            if (s_axis_tvalid && w_tready && s_axis_tuser) begin
               w_emit = 1'b1;
               w_cx   = '0;
               w_cy   = '0;
            end
         end
         PASS: begin
            w_tready = w_out_en;
            if (s_axis_tvalid && w_tready) begin
               w_emit = 1'b1;
               if (s_axis_tuser) begin
                  w_sof_err = (r_x != '0) || (r_y != '0);
                  w_cx      = '0;
                  w_cy      = '0;
               end
            end
         end
         PAD: begin
            if (w_out_en) begin
               w_load = 1'b1;
               w_dat  = PAD_VALUE;
               w_last = (r_x == X_LAST);
               w_eof  = (r_x == X_LAST) && (r_y == Y_LAST);
               if (r_x == X_LAST) begin
                  w_x_nxt = '0;
                  if (r_y == Y_LAST) begin
                     w_y_nxt     = '0;
                     w_state_nxt = WAIT_SOF;
                  end else begin
                     w_y_nxt     = r_y + C_ONE;
                     w_state_nxt = PASS;
                  end
               end else begin
                  w_x_nxt = r_x + C_ONE;
               end
            end
         end
         DROP: begin
            // A fresh SOF here restarts the frame, so it needs the output slot like in PASS.
            w_tready = w_out_en || !s_axis_tuser;
            if (s_axis_tvalid && w_tready) begin
               if (s_axis_tuser) begin
                  w_sof_err = 1'b1;
                  w_emit    = 1'b1;
                  w_cx      = '0;
                  w_cy      = '0;
               end else if (s_axis_tlast) begin
                  w_state_nxt = r_drop_eof ? WAIT_SOF : PASS;
               end
            end
         end
         default: begin
            w_state_nxt = WAIT_SOF;
         end
      endcase

      // Common handling of an input pixel placed at (w_cx, w_cy).
      if (w_emit) begin
         w_load = 1'b1;
         w_dat  = s_axis_tdata;
         w_user = (w_cx == '0) && (w_cy == '0);
         w_last = (w_cx == X_LAST);
         w_eof  = (w_cx == X_LAST) && (w_cy == Y_LAST);
         if (s_axis_tlast && (w_cx != X_LAST)) begin
            w_short     = 1'b1;
            w_x_nxt     = w_cx + C_ONE;
            w_y_nxt     = w_cy;
            w_state_nxt = PAD;
         end else if (w_cx == X_LAST) begin
            w_x_nxt = '0;
            w_y_nxt = (w_cy == Y_LAST) ? '0 : w_cy + C_ONE;
            if (!s_axis_tlast) begin
               w_long         = 1'b1;
               w_drop_eof_nxt = (w_cy == Y_LAST);
               w_state_nxt    = DROP;
            end else begin
               w_state_nxt = (w_cy == Y_LAST) ? WAIT_SOF : PASS;
            end
         end else begin
            w_x_nxt     = w_cx + C_ONE;
            w_y_nxt     = w_cy;
            w_state_nxt = PASS;
         end
      end

      // Nothing is accepted or reported while reset is held.
      if (rst) begin
         w_tready  = 1'b0;
         w_load    = 1'b0;
         w_short   = 1'b0;
         w_long    = 1'b0;
         w_sof_err = 1'b0;
      end
   end

   axis_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .i_out_en (w_out_en),
      .i_vld    (w_load),
      .i_dat    (w_dat),
      .i_last   (w_last),
      .i_user   (w_user),
      .o_vld    (m_axis_tvalid),
      .o_dat    (m_axis_tdata),
      .o_last   (m_axis_tlast),
      .o_user   (m_axis_tuser)
   );

   // Tag the output slot when it carries the final pixel of a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_eof <= 1'b0;
      end else if (w_out_en) begin
         r_out_eof <= w_load && w_eof;
      end
   end

   assign s_axis_tready  = w_tready;
   assign err_short_line = w_short;
   assign err_long_line  = w_long;
   assign err_early_sof  = w_sof_err;
   assign frame_done     = r_out_eof && m_axis_tvalid && m_axis_tready && !rst;

`ifdef AXIS_FRAME_CONFORMER_STATS_EN
   logic [15:0] r_cnt_short;
   logic [15:0] r_cnt_long;
   logic [15:0] r_cnt_sof;
   logic [15:0] r_cnt_frames;

   // Saturating anomaly and frame counters; clear wins over a simultaneous pulse.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         r_cnt_short  <= '0;
         r_cnt_long   <= '0;
         r_cnt_sof    <= '0;
         r_cnt_frames <= '0;
      end else begin
         if (w_short)    r_cnt_short  <= sat_inc16(r_cnt_short);
         if (w_long)     r_cnt_long   <= sat_inc16(r_cnt_long);
         if (w_sof_err)  r_cnt_sof    <= sat_inc16(r_cnt_sof);
         if (frame_done) r_cnt_frames <= sat_inc16(r_cnt_frames);
      end
   end

   assign cnt_short_line = r_cnt_short;
   assign cnt_long_line  = r_cnt_long;
   assign cnt_early_sof  = r_cnt_sof;
   assign cnt_frames     = r_cnt_frames;
`endif

endmodule

// File: tb/tb_axis_frame_conformer.sv
// Self-checking bench for axis_frame_conformer with WIDTH=4, HEIGHT=2, PAD_VALUE=0.
// A beat-level reference model predicts the output stream and pulses from accepted input beats.
// Directed frames pin the model with literal expectations, then randomized traffic follows.
module tb_axis_frame_conformer;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int DW = 24;
   localparam logic [DW-1:0] PADV = '0;

   logic          clk;
   logic          rst;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tuser;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          m_axis_tready;
   logic          err_short_line;
   logic          err_long_line;
   logic          err_early_sof;
   logic          frame_done;
`ifdef AXIS_FRAME_CONFORMER_STATS_EN
   logic          stats_clr;
   logic [15:0]   cnt_short_line;
   logic [15:0]   cnt_long_line;
   logic [15:0]   cnt_early_sof;
   logic [15:0]   cnt_frames;
`endif

   axis_frame_conformer #(
      .WIDTH       (W),
      .HEIGHT      (H),
      .DATA_WIDTH  (DW),
      .COORD_WIDTH (16),
      .PAD_VALUE   (PADV)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tlast   (s_axis_tlast),
      .s_axis_tuser   (s_axis_tuser),
      .s_axis_tready  (s_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tready  (m_axis_tready),
      .err_short_line (err_short_line),
      .err_long_line  (err_long_line),
      .err_early_sof  (err_early_sof),
      .frame_done     (frame_done)
`ifdef AXIS_FRAME_CONFORMER_STATS_EN
      ,
      .stats_clr      (stats_clr),
      .cnt_short_line (cnt_short_line),
      .cnt_long_line  (cnt_long_line),
      .cnt_early_sof  (cnt_early_sof),
      .cnt_frames     (cnt_frames)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
      logic          u;
      logic          eof;
   } exp_t;

   exp_t exp_q[$];
   bit   m_active;
   bit   m_dropping;
   bit   m_drop_eof;
   int   m_x;
   int   m_y;

   // Log of observed output beats and pulse tallies (written only by the monitor).
   logic [DW-1:0] log_d[$];
   logic          log_l[$];
   logic          log_u[$];
   int cnt_es = 0, cnt_el = 0, cnt_ee = 0, cnt_fd = 0;

   task automatic model_step(input logic [DW-1:0] d, input logic l, input logic u,
                             output logic es, output logic el, output logic ee,
                             output logic emitted);
      exp_t e;
      es = 0; el = 0; ee = 0; emitted = 0;
      if (u) begin
         if (m_dropping || (m_active && (m_x != 0 || m_y != 0))) ee = 1;
         m_active = 1; m_dropping = 0; m_x = 0; m_y = 0;
      end
      if (!m_active) return;
      if (m_dropping) begin
         if (l) begin
            m_dropping = 0;
            if (m_drop_eof) m_active = 0;
         end
         return;
      end
      e.d = d; e.l = (m_x == W-1); e.u = (m_x == 0 && m_y == 0);
      e.eof = (m_x == W-1 && m_y == H-1);
      exp_q.push_back(e);
      emitted = 1;
      if (m_x == W-1) begin
         if (!l) begin
            el = 1; m_dropping = 1; m_drop_eof = (m_y == H-1);
         end else if (m_y == H-1) begin
            m_active = 0;
         end
         m_x = 0; m_y = (m_y == H-1) ? 0 : m_y + 1;
      end else if (l) begin
         es = 1;
         for (int i = m_x + 1; i < W; i++) begin
            e.d = PADV; e.l = (i == W-1); e.u = 0; e.eof = (i == W-1 && m_y == H-1);
            exp_q.push_back(e);
         end
         if (m_y == H-1) m_active = 0;
         m_x = 0; m_y = (m_y == H-1) ? 0 : m_y + 1;
      end else begin
         m_x++;
      end
   endtask

   // ---------------- monitor / compare ----------------
   bit            prev_stall;
   logic [DW-1:0] p_d;
   logic          p_l, p_u;
   bit            exp_vld_next;

   always @(negedge clk) begin
      logic es, el, ee, em;
      exp_t e;
      if (rst) begin
         exp_q.delete();
         m_active = 0; m_dropping = 0; m_drop_eof = 0; m_x = 0; m_y = 0;
         prev_stall = 0; exp_vld_next = 0;
      end else begin
         if (exp_vld_next) check("latency_vld", m_axis_tvalid, 1);
         exp_vld_next = 0;
         if (prev_stall) begin
            check("hold_vld", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, p_d);
            check("hold_last", m_axis_tlast, p_l);
            check("hold_user", m_axis_tuser, p_u);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         p_d = m_axis_tdata; p_l = m_axis_tlast; p_u = m_axis_tuser;

         if (m_axis_tvalid && m_axis_tready) begin
            log_d.push_back(m_axis_tdata);
            log_l.push_back(m_axis_tlast);
            log_u.push_back(m_axis_tuser);
            if (exp_q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", m_axis_tdata, e.d);
               check("out_last", m_axis_tlast, e.l);
               check("out_user", m_axis_tuser, e.u);
               check("frame_done", frame_done, e.eof);
            end
         end else begin
            check("frame_done_idle", frame_done, 0);
         end

         es = 0; el = 0; ee = 0; em = 0;
         if (s_axis_tvalid && s_axis_tready)
            model_step(s_axis_tdata, s_axis_tlast, s_axis_tuser, es, el, ee, em);
         check("err_short", err_short_line, es);
         check("err_long", err_long_line, el);
         check("err_sof", err_early_sof, ee);
         if (em) exp_vld_next = 1;
         cnt_es += int'(err_short_line);
         cnt_el += int'(err_long_line);
         cnt_ee += int'(err_early_sof);
         cnt_fd += int'(frame_done);
      end
   end

   // ---------------- downstream ready driver ----------------
   int       bp_mode = 0;
   logic [3:0] bp_pat = 4'b1001;
   initial begin
      int idx;
      idx = 0;
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            0:       m_axis_tready = 1'b1;
            1: begin m_axis_tready = bp_pat[idx]; idx = (idx + 1) % 4; end
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [DW-1:0] d, input logic l, input logic u, output int stalls);
      bit done;
      done = 0; stalls = 0;
      s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (s_axis_tready) done = 1; else stalls++;
         @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0;
      if (!done) check("send_timeout", 1, 0);
   endtask

   task automatic send_clean_frame(input int base);
      int st;
      for (int i = 0; i < W*H; i++)
         send(DW'(base + i + 1), (i % W) == W-1, i == 0, st);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
         @(posedge clk); #1; n++;
      end
      check("drain_timeout", n < 500, 1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic check_stream(input string nm, input int base, input int n,
                               input logic [DW-1:0] d[16], input logic [15:0] um,
                               input logic [15:0] lm);
      check({nm, "_count"}, log_d.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < log_d.size()) begin
            check({nm, "_data"}, log_d[base+i], d[i]);
            check({nm, "_user"}, log_u[base+i], um[i]);
            check({nm, "_last"}, log_l[base+i], lm[i]);
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int base, b_es, b_el, b_ee, b_fd, st;
      logic [DW-1:0] ed[16];

      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
`ifdef AXIS_FRAME_CONFORMER_STATS_EN
      stats_clr = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(negedge clk);
      check("rst_m_vld", m_axis_tvalid, 0);
      check("rst_m_last", m_axis_tlast, 0);
      check("rst_m_user", m_axis_tuser, 0);
      check("rst_m_data", m_axis_tdata, 0);
      check("rst_pulses", {err_short_line, err_long_line, err_early_sof, frame_done}, 0);
      check("rst_s_rdy", s_axis_tready, 1);
      @(posedge clk); #1;

      // Clean frame.
      base = log_d.size(); b_es = cnt_es; b_el = cnt_el; b_ee = cnt_ee; b_fd = cnt_fd;
      send_clean_frame(0);
      drain();
      ed = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
      check_stream("clean", base, 8, ed, 16'h0001, 16'h0088);
      check("clean_fdone", cnt_fd - b_fd, 1);
      check("clean_errs", (cnt_es - b_es) + (cnt_el - b_el) + (cnt_ee - b_ee), 0);

      // Short first line, padded.
      base = log_d.size(); b_es = cnt_es; b_fd = cnt_fd;
      send(1, 0, 1, st); send(2, 0, 0, st); send(3, 1, 0, st);
      send(4, 0, 0, st);
      check("short_pad_stall", st, 1);
      send(5, 0, 0, st); send(6, 0, 0, st); send(7, 1, 0, st);
      drain();
      ed = '{1, 2, 3, 0, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
      check_stream("short", base, 8, ed, 16'h0001, 16'h0088);
      check("short_cnt", cnt_es - b_es, 1);
      check("short_fdone", cnt_fd - b_fd, 1);

      // Long first line, truncated.
      base = log_d.size(); b_el = cnt_el;
      send(1, 0, 1, st);
      for (int i = 2; i <= 6; i++) send(DW'(i), i == 6, 0, st);
      for (int i = 7; i <= 10; i++) send(DW'(i), i == 10, 0, st);
      drain();
      ed = '{1, 2, 3, 4, 7, 8, 9, 10, 0, 0, 0, 0, 0, 0, 0, 0};
      check_stream("long", base, 8, ed, 16'h0001, 16'h0088);
      check("long_cnt", cnt_el - b_el, 1);

      // Pre-SOF garbage, then early SOF at (2,0).
      base = log_d.size(); b_ee = cnt_ee; b_fd = cnt_fd;
      send(24'hAA, 0, 0, st); send(24'hBB, 0, 0, st);
      send(1, 0, 1, st); send(2, 0, 0, st); send(3, 0, 1, st);
      for (int i = 4; i <= 10; i++) send(DW'(i), i == 6 || i == 10, 0, st);
      drain();
      ed = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0, 0, 0, 0, 0};
      check_stream("esof", base, 10, ed, 16'h0005, 16'h0220);
      check("esof_cnt", cnt_ee - b_ee, 1);
      check("esof_fdone", cnt_fd - b_fd, 1);

      // Backpressure 1,0,0,1 on a clean frame.
      base = log_d.size();
      bp_mode = 1;
      send_clean_frame(0);
      drain();
      bp_mode = 0;
      ed = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
      check_stream("bp", base, 8, ed, 16'h0001, 16'h0088);

      // Reset mid-frame with a beat parked in the output register.
      send(1, 0, 1, st); send(2, 0, 0, st); send(3, 0, 0, st);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_pre_vld", m_axis_tvalid, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_vld", m_axis_tvalid, 0);
      @(posedge clk); #1;
      base = log_d.size();
      send_clean_frame(10);
      drain();
      ed = '{11, 12, 13, 14, 15, 16, 17, 18, 0, 0, 0, 0, 0, 0, 0, 0};
      check_stream("midrst", base, 8, ed, 16'h0001, 16'h0088);

      // Randomized frames with anomalies, gaps and backpressure.
      bp_mode = 2;
      for (int f = 0; f < 40; f++) begin
         int ng;
         ng = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
         for (int g = 0; g < ng; g++) send(DW'($urandom), $urandom_range(0, 1), 0, st);
         for (int ln = 0; ln < H; ln++) begin
            int len;
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : W;
            for (int i = 0; i < len; i++) begin
               logic u;
               u = (ln == 0 && i == 0) || ($urandom_range(0, 39) == 0);
               if ($urandom_range(0, 3) == 0)
                  repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
               send(DW'($urandom), i == len - 1, u, st);
            end
         end
      end
      drain();
      bp_mode = 0;
      check("final_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axis_frame_conformer.md
Name: axis_frame_conformer

Overview:
- Upstream stage of barrel_distortion_correction: forces an arbitrary AXI4-Stream video source into exact WIDTH×HEIGHT frames.
- Output guarantees: tuser on pixel (0,0) only, tlast exactly on x==WIDTH-1, precisely WIDTH×HEIGHT beats per frame.
- Short lines are padded, long lines truncated, pixels before SOF discarded; each anomaly is reported as a status pulse.

Parameters:
WIDTH, 1920, output pixels per line
HEIGHT, 1080, output lines per frame
DATA_WIDTH, 24, pixel width (RGB888)
COORD_WIDTH, 16, x/y counter width
PAD_VALUE, 0, pixel value inserted for missing pixels (DATA_WIDTH bits)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  input pixel
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end of line
s_axis_tuser  in  1  input start of frame
s_axis_tready  out  1  input ready (combinational)
m_axis_tdata  out  DATA_WIDTH  conformed pixel
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  end of line
m_axis_tuser  out  1  start of frame
m_axis_tready  in  1  downstream ready
err_short_line  out  1  1-cycle pulse: input tlast with x<WIDTH-1
err_long_line  out  1  1-cycle pulse: no input tlast at x==WIDTH-1
err_early_sof  out  1  1-cycle pulse: tuser inside a frame
frame_done  out  1  1-cycle pulse: beat (WIDTH-1,HEIGHT-1) accepted downstream

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset: state=WAIT_SOF, x=y=0; m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, all pulses 0.
- Reset applied mid-frame abandons the frame at once. The output register is cleared even if tvalid was high; the next frame requires a fresh tuser.
- Output register: loads when out_en = !m_axis_tvalid || m_axis_tready. Held stable while tvalid && !tready.
- Latency: 1 cycle from input acceptance to m_axis_tvalid. Sustains 1 pixel/clk at full throughput.
- States:
  - WAIT_SOF:
    - s_axis_tready=1; beats without tuser are discarded.
    - Beat with tuser accepted while out_en → emit it as (0,0) with m_tuser=1, go to PASS.
    - Beat with tuser while !out_en → tready=0 until out_en.
  - PASS:
    - s_axis_tready=out_en; each accepted beat is emitted at (x,y) with m_tlast=(x==WIDTH-1).
    - Input tlast at x<WIDTH-1 → err_short_line, go to PAD.
    - x==WIDTH-1 without input tlast → err_long_line, go to DROP.
    - Input tuser with (x,y)!=(0,0) → err_early_sof; restart the frame with this beat as (0,0), m_tuser=1. No padding of the abandoned frame.
  - PAD:
    - s_axis_tready=0; emit PAD_VALUE on each out_en cycle until x==WIDTH-1 (with m_tlast).
  - DROP:
    - s_axis_tready=1; discard beats up to and including the one with tlast.
    - A tuser seen in DROP → err_early_sof; treated as in PASS.
- Line end: x wraps to 0, y increments.
  - After y==HEIGHT-1's line ends, go to WAIT_SOF (via PAD/DROP if needed).
  - Last line long → DROP, then WAIT_SOF.
- Simultaneous tuser+tlast on the same beat (WIDTH>1): treated as SOF, then short line → PAD.
- Counters: x, y are COORD_WIDTH unsigned, compared with ==; never exceed WIDTH-1/HEIGHT-1.
- Pulses: asserted for exactly one cycle on the cycle the triggering input beat is accepted.
- frame_done: asserted when the final beat handshakes on m_axis.

Optional Feature:
- Macro: AXIS_FRAME_CONFORMER_STATS_EN.
- Defined: adds outputs cnt_short_line, cnt_long_line, cnt_early_sof, cnt_frames, each 16 bits.
  - Counters saturate at 16'hFFFF; they increment on the matching pulse (cnt_frames on frame_done).
  - Cleared by rst and by an added input stats_clr (1 bit, synchronous). stats_clr together with a pulse → result 0.
- Undefined: these ports and registers do not exist; behaviour otherwise identical.

Decomposition:
- Package video_axis_pkg holds:
  - state enum {WAIT_SOF, PASS, PAD, DROP} (2 bits)
  - default WIDTH/HEIGHT/DATA_WIDTH/COORD_WIDTH constants shared with barrel_distortion_correction.
- One sub-module, axis_out_reg: a single-entry AXI4-Stream output register with tdata/tlast/tuser, load enable out_en and clear on rst.
- The FSM and counters stay in the top module.

Test Plan (WIDTH=4, HEIGHT=2, PAD_VALUE=0):
- Clean frame: tuser on first beat, tlast every 4th beat, data 1..8, tready=1 → output 1..8; tuser on beat 1; tlast on beats 4 and 8; frame_done once; no errors.
- Short line: line 0 = 1,2,3 with tlast on 3 → output 1,2,3,0 (tlast on 0); err_short_line once; s_axis_tready=0 for the pad cycle.
- Long line: line 0 = 1..6 with tlast on 6 → output 1..4; beats 5,6 discarded; err_long_line once; line 1 is unaffected.
- Pre-SOF garbage and early SOF: 0xAA,0xBB without tuser, then a frame; a second tuser at (2,0) → the 0xAA/0xBB beats are dropped; err_early_sof once; the new frame starts with m_tuser=1.
- Backpressure: m_axis_tready toggling 1,0,0,1 on the clean frame → m_axis_tdata/tlast/tuser held stable while stalled; no beat lost or duplicated.
- Reset mid-frame after 3 beats with m_axis_tvalid=1 → next cycle m_axis_tvalid=0. The next frame's first output pixel carries m_tuser=1 at (0,0).
